note_duration_timer: RTL and testbench

- Programmable down-counting duration timer. It loads a note length, counts it down to zero in prescaled ticks, then signals completion with a one-cycle pulse.
- It is the complement of the free-running up-counter: instead of counting up from reset, it counts a loaded value down and reports when it expires.
- Sits between the note sequencer (which issues start/duration) and the tone generator (which gates output on busy).

---
 rtl/note_duration_timer.sv | 80 ++++++++
 tb/tb_note_duration_timer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/note_duration_timer.sv
// Programmable down-counting note duration timer: loads a length in ticks,
// counts it down at one tick per PRESCALE clocks, and pulses done on expiry.
module note_duration_timer #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] duration,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] remaining
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state;
   logic [PW-1:0] prescaler;

   // Timer FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         prescaler <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (duration != '0) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     remaining <= duration;
                     prescaler <= '0;
                  end else begin
                     // A zero-length note expires immediately without running.
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  remaining <= '0;
                  prescaler <= '0;
               end else if (prescaler == PRE_MAX) begin
                  prescaler <= '0;
                  if (remaining == WIDTH'(1)) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     remaining <= '0;
                  end else if (remaining != '0) begin
                     remaining <= remaining - WIDTH'(1);
                  end
               end else begin
                  prescaler <= prescaler + PW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_duration_timer.sv
// Bench for note_duration_timer: table-driven vectors on a PRESCALE=4 instance,
// plus hand sequences for async reset and a PRESCALE=1, WIDTH=4 instance.
module tb_note_duration_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort;
   logic [15:0] duration;
   logic        busy, done;
   logic [15:0] remaining;

   logic        start1, abort1;
   logic [3:0]  duration1;
   logic        busy1, done1;
   logic [3:0]  remaining1;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   note_duration_timer #(.WIDTH(16), .PRESCALE(4)) dut (
      .clk(clk), .reset(reset), .start(start), .duration(duration), .abort(abort),
      .busy(busy), .done(done), .remaining(remaining)
   );

   note_duration_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .duration(duration1), .abort(abort1),
      .busy(busy1), .done(done1), .remaining(remaining1)
   );

   typedef struct {
      logic        start;
      logic [15:0] dur;
      logic        abort;
      logic        busy;
      logic        done;
      logic [15:0] rem;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic s, input logic [15:0] d, input logic a,
                               input logic b, input logic dn, input logic [15:0] r);
      vec_t v;
      v.start = s; v.dur = d; v.abort = a; v.busy = b; v.done = dn; v.rem = r;
      vecs.push_back(v);
   endfunction

   function automatic void hold(input int n, input logic b, input logic dn,
                                input logic [15:0] r);
      for (int k = 0; k < n; k++) add(1'b0, 16'd0, 1'b0, b, dn, r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Basic countdown, duration 3 -> done 12 edges after start.
      add(1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 16'd3);
      hold(3, 1'b1, 1'b0, 16'd3);
      hold(4, 1'b1, 1'b0, 16'd2);
      hold(4, 1'b1, 1'b0, 16'd1);
      hold(1, 1'b0, 1'b1, 16'd0);
      hold(1, 1'b0, 1'b0, 16'd0);
      // Zero duration: one-cycle done, never busy.
      add(1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0);
      hold(2, 1'b0, 1'b0, 16'd0);
      // Back-to-back zero-duration starts: done high on consecutive cycles.
      add(1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0);
      add(1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0);
      hold(1, 1'b0, 1'b0, 16'd0);
      // Abort in IDLE is ignored.
      add(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      // Abort at edge 7 of a duration-5 note.
      add(1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 16'd5);
      hold(3, 1'b1, 1'b0, 16'd5);
      hold(3, 1'b1, 1'b0, 16'd4);
      add(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      hold(2, 1'b0, 1'b0, 16'd0);
      // Abort on the expiry edge suppresses done.
      add(1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 16'd1);
      hold(3, 1'b1, 1'b0, 16'd1);
      add(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      hold(1, 1'b0, 1'b0, 16'd0);
      // Start and abort together while running: abort wins.
      add(1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 16'd2);
      add(1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 16'd0);
      hold(1, 1'b0, 1'b0, 16'd0);
      // Start while busy ignored, then back-to-back start in the done cycle.
      add(1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 16'd2);
      hold(2, 1'b1, 1'b0, 16'd2);
      add(1'b1, 16'd9, 1'b0, 1'b1, 1'b0, 16'd2);
      hold(4, 1'b1, 1'b0, 16'd1);
      hold(1, 1'b0, 1'b1, 16'd0);
      add(1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 16'd1);
      hold(3, 1'b1, 1'b0, 16'd1);
      hold(1, 1'b0, 1'b1, 16'd0);
      hold(1, 1'b0, 1'b0, 16'd0);

      start = 1'b0; abort = 1'b0; duration = '0;
      start1 = 1'b0; abort1 = 1'b0; duration1 = '0;
      reset = 1'b0;
      #1;
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.rem", 32'(remaining), 32'd0);
      tick();
      chk("reset_held.busy", 32'(busy), 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         start = vecs[i].start; duration = vecs[i].dur; abort = vecs[i].abort;
         tick();
         chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].done));
         chk($sformatf("vec%0d.rem", i), 32'(remaining), 32'(vecs[i].rem));
      end
      start = 1'b0; abort = 1'b0; duration = '0;

      // Async reset in the middle of a long note, asserted between edges.
      start = 1'b1; duration = 16'd100;
      tick();
      start = 1'b0; duration = 16'd0;
      chk("areset.pre_busy", 32'(busy), 32'd1);
      repeat (10) tick();
      chk("areset.pre_rem", 32'(remaining), 32'd98);
      #2 reset = 1'b0;
      #1;
      chk("areset.busy", 32'(busy), 32'd0);
      chk("areset.rem", 32'(remaining), 32'd0);
      chk("areset.done", 32'(done), 32'd0);
      #1 reset = 1'b1;
      repeat (5) begin
         tick();
         chk("areset.idle_busy", 32'(busy), 32'd0);
         chk("areset.idle_done", 32'(done), 32'd0);
      end
      start = 1'b1; duration = 16'd2;
      tick();
      start = 1'b0;
      chk("areset.restart_busy", 32'(busy), 32'd1);
      chk("areset.restart_rem", 32'(remaining), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("areset.restart_abort", 32'(busy), 32'd0);

      // PRESCALE=1, WIDTH=4: maximum duration decrements every cycle.
      start1 = 1'b1; duration1 = 4'd15;
      tick();
      start1 = 1'b0; duration1 = 4'd0;
      chk("p1.busy0", 32'(busy1), 32'd1);
      chk("p1.rem0", 32'(remaining1), 32'd15);
      for (int k = 1; k < 15; k++) begin
         tick();
         chk($sformatf("p1.rem%0d", k), 32'(remaining1), 32'(15 - k));
         chk($sformatf("p1.done%0d", k), 32'(done1), 32'd0);
      end
      tick();
      chk("p1.expiry_done", 32'(done1), 32'd1);
      chk("p1.expiry_busy", 32'(busy1), 32'd0);
      chk("p1.expiry_rem", 32'(remaining1), 32'd0);
      tick();
      chk("p1.after_done", 32'(done1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
